// File: rtl/pre_if_stage.sv
// pre_if_stage: next-PC selection and fetch request issue; optional PRE_IF_ADEF_EN flags misaligned PCs as adef
module pre_if_stage (
   input  logic        clk,
   input  logic        reset,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [31:0] inst_sram_addr,
   input  logic        inst_sram_addr_ok,
   input  logic        if_allowin,
   input  logic [33:0] br_bus,
   input  logic        flush,
   input  logic [31:0] excep_entry,
   output logic        to_if_valid,
   output logic [32:0] to_if_bus
);
   logic [31:0] pc_reg, redir_pc, pre_pc, br_target;
   logic        redir_valid, redir_is_flush, pre_adef, br_stall, br_taken, go, hs;
   assign {br_stall, br_taken, br_target} = br_bus;
   assign pre_pc = flush ? excep_entry : redir_valid ? redir_pc : br_taken ? br_target : pc_reg + 32'd4;
`ifdef PRE_IF_ADEF_EN
   assign pre_adef = |pre_pc[1:0];
`else
   assign pre_adef = 1'b0;
`endif
   assign go             = ~reset & if_allowin & (~br_stall | flush);
   assign inst_sram_req  = go & ~pre_adef;
   assign hs             = go & (pre_adef | inst_sram_addr_ok);
   assign inst_sram_wr   = 1'b0;
   assign inst_sram_size = 2'b10;
   assign inst_sram_addr = pre_pc;
   assign to_if_valid    = hs;
   assign to_if_bus      = {pre_pc, pre_adef};
   // advance the PC on handshake, otherwise remember any redirect so it is not lost; a flush is never displaced by a branch
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg         <= 32'h1bfffffc;
         redir_valid    <= 1'b0;
         redir_is_flush <= 1'b0;
         redir_pc       <= 32'h0;
      end else if (hs) begin
         pc_reg         <= pre_pc;
         redir_valid    <= 1'b0;
         redir_is_flush <= 1'b0;
      end else if (flush) begin
         redir_valid    <= 1'b1;
         redir_is_flush <= 1'b1;
         redir_pc       <= excep_entry;
      end else if (br_taken & ~br_stall & ~(redir_valid & redir_is_flush)) begin
         redir_valid    <= 1'b1;
         redir_is_flush <= 1'b0;
         redir_pc       <= br_target;
      end
   end
endmodule

// File: tb/tb_pre_if_stage.sv
// tb_pre_if_stage: randomized scoreboard bench for pre_if_stage against a fetch-order reference model
module tb_pre_if_stage;
`ifdef PRE_IF_ADEF_EN
   localparam bit ADEF = 1'b1;
`else
   localparam bit ADEF = 1'b0;
`endif
   logic        clk = 1'b0, reset = 1'b1;
   logic        inst_sram_req, inst_sram_wr, inst_sram_addr_ok = 1'b0, if_allowin = 1'b0;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr, excep_entry = 32'h0;
   logic [33:0] br_bus = 34'h0;
   logic        flush = 1'b0, to_if_valid;
   logic [32:0] to_if_bus;

   pre_if_stage dut (
      .clk(clk), .reset(reset), .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
      .inst_sram_addr_ok(inst_sram_addr_ok), .if_allowin(if_allowin), .br_bus(br_bus),
      .flush(flush), .excep_entry(excep_entry), .to_if_valid(to_if_valid), .to_if_bus(to_if_bus)
   );

   always #5 clk = ~clk;

   typedef struct {int c; logic req; logic [31:0] addr; logic chk_addr;} req_t;
   typedef struct {int c; logic [32:0] bus;} hs_t;
   req_t req_q[$];
   hs_t  hs_q[$];
   int   n_tests = 0, n_fail = 0, cyc = 0;

   // reference state: last handed-over PC and an optional pending redirect target
   logic [31:0] m_pc, m_tgt, n_pc = 32'h1bfffffc, n_tgt = 32'h0;
   logic        m_pend, m_pend_fl, n_pend = 1'b0, n_pend_fl = 1'b0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   task automatic step(input logic r, input logic al, input logic ok, input logic st, input logic tk,
                       input logic fl, input logic [31:0] tgt, input logic [31:0] ent);
      logic [31:0] pc;
      logic        ad, rq, h, blocked;
      @(posedge clk);
      m_pc = n_pc; m_tgt = n_tgt; m_pend = n_pend; m_pend_fl = n_pend_fl;
      #1;
      cyc++;
      reset = r; if_allowin = al; inst_sram_addr_ok = ok; br_bus = {st, tk, tgt}; flush = fl; excep_entry = ent;
      blocked = st && !fl;
      if (fl) pc = ent;
      else if (m_pend) pc = m_tgt;
      else if (tk) pc = tgt;
      else pc = m_pc + 32'd4;
      ad = ADEF && (pc[1:0] != 2'b00);
      rq = !r && al && !blocked && !ad;
      h  = !r && al && !blocked && (ad || ok);
      req_q.push_back('{cyc, rq, pc, !r});
      if (h) hs_q.push_back('{cyc, {pc, ad}});
      if (r) begin
         n_pc = 32'h1bfffffc; n_tgt = 32'h0; n_pend = 1'b0; n_pend_fl = 1'b0;
      end else if (h) begin
         n_pc = pc; n_pend = 1'b0; n_pend_fl = 1'b0;
      end else if (fl) begin
         n_pend = 1'b1; n_pend_fl = 1'b1; n_tgt = ent;
      end else if (tk && !st && !(m_pend && m_pend_fl)) begin
         n_pend = 1'b1; n_pend_fl = 1'b0; n_tgt = tgt;
      end
   endtask

   // monitor: per-cycle request expectations and handshake scoreboard
   always @(negedge clk) begin
      req_t e;
      hs_t  h;
      if (req_q.size() != 0) begin
         e = req_q.pop_front();
         chk("req", 64'(inst_sram_req), 64'(e.req));
         chk("wr_size", {61'h0, inst_sram_wr, inst_sram_size}, 64'h2);
         if (e.chk_addr) chk("addr", 64'(inst_sram_addr), 64'(e.addr));
      end
      if (to_if_valid === 1'b1) begin
         if (hs_q.size() == 0) chk("unexpected_hs", 64'(to_if_bus), 64'h1_0000_0000_0000);
         else begin
            h = hs_q.pop_front();
            chk("hs_cycle", 64'(cyc), 64'(h.c));
            chk("hs_bus", 64'(to_if_bus), 64'(h.bus));
         end
      end else if (hs_q.size() != 0 && hs_q[0].c <= cyc) begin
         h = hs_q.pop_front();
         chk("missed_hs", 64'(to_if_valid), 64'h1);
      end
   end

   initial begin
      logic [31:0] tgt, ent;
      step(1, 1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rst_req", 64'(inst_sram_req), 64'h0);
      chk("rst_valid", 64'(to_if_valid), 64'h0);
      step(0, 1, 1, 0, 0, 0, 0, 0); @(negedge clk);
      chk("seq0", 64'(to_if_bus), {31'h0, 32'h1c000000, 1'b0});
      step(0, 1, 1, 0, 0, 0, 0, 0); @(negedge clk);
      chk("seq1", 64'(to_if_bus), {31'h0, 32'h1c000004, 1'b0});
      step(0, 1, 1, 0, 0, 0, 0, 0); @(negedge clk);
      chk("seq2", 64'(to_if_bus), {31'h0, 32'h1c000008, 1'b0});
      step(1, 1, 1, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, 0, 0, 0, 0); @(negedge clk);
         chk("hold_addr", 64'(inst_sram_addr), 64'h1c000004);
         chk("hold_req", 64'(inst_sram_req), 64'h1);
         chk("hold_valid", 64'(to_if_valid), 64'h0);
      end
      step(0, 1, 1, 0, 0, 0, 0, 0); @(negedge clk);
      chk("hold_hs", 64'(to_if_bus), {31'h0, 32'h1c000004, 1'b0});
      step(0, 1, 0, 0, 1, 0, 32'h1c000100, 0); @(negedge clk);
      chk("br_addr", 64'(inst_sram_addr), 64'h1c000100);
      step(0, 1, 0, 0, 0, 1, 0, 32'h1c008000);
      step(0, 1, 0, 0, 0, 0, 0, 0); @(negedge clk);
      chk("flush_pend", 64'(inst_sram_addr), 64'h1c008000);
      step(0, 1, 1, 0, 0, 0, 0, 0); @(negedge clk);
      chk("flush_hs", 64'(to_if_bus), {31'h0, 32'h1c008000, 1'b0});
      step(0, 1, 1, 0, 0, 0, 0, 0); @(negedge clk);
      chk("flush_seq", 64'(to_if_bus), {31'h0, 32'h1c008004, 1'b0});
      for (int i = 0; i < 2; i++) begin
         step(0, 1, 1, 1, 0, 0, 0, 0); @(negedge clk);
         chk("stall_req", 64'(inst_sram_req), 64'h0);
         chk("stall_valid", 64'(to_if_valid), 64'h0);
      end
      step(0, 1, 1, 0, 1, 0, 32'h1c000200, 0); @(negedge clk);
      chk("br_same_hs", 64'(to_if_bus), {31'h0, 32'h1c000200, 1'b0});
      step(0, 1, 1, 0, 0, 0, 0, 0); @(negedge clk);
      chk("br_no_latch", 64'(inst_sram_addr), 64'h1c000204);
      step(0, 1, 1, 0, 1, 0, 32'h1c000102, 0); @(negedge clk);
      chk("mis_valid", 64'(to_if_valid), 64'h1);
      chk("mis_req", 64'(inst_sram_req), ADEF ? 64'h0 : 64'h1);
      chk("mis_bus", 64'(to_if_bus), {31'h0, 32'h1c000102, ADEF});
      for (int i = 0; i < 3000; i++) begin
         tgt = 32'h1c000000 + ($urandom_range(0, 255) << 2) + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
         ent = 32'h1c008000 + ($urandom_range(0, 15) << 2) + (($urandom_range(0, 15) == 0) ? 32'h2 : 32'h0);
         step($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6,
              $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 11) == 0, tgt, ent);
      end
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      chk("drain", 64'(hs_q.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pre_if_stage.md
PRE_IF_STAGE -- requirements
Module: pre_if_stage

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-high: clk input 1, rising-edge clock for all state; reset input 1, synchronous, active-high.
REQ-002 SHALL expose: inst_sram_req output 1, fetch request.
REQ-003 SHALL expose: inst_sram_wr output 1, tied 0.
REQ-004 SHALL expose: inst_sram_size output 2, tied 2'b10 (word).
REQ-005 SHALL expose: inst_sram_addr output 32, fetch address (pre_pc).
REQ-006 SHALL expose: inst_sram_addr_ok input 1, address accepted this cycle.
REQ-007 SHALL expose: if_allowin input 1, IF stage can accept a new PC.
REQ-008 SHALL expose: br_bus input 34, {br_stall, br_taken, br_target[31:0]} from ID.
REQ-009 SHALL expose: flush input 1, exception/ertn flush from WB.
REQ-010 SHALL expose: excep_entry input 32, flush target.
REQ-011 SHALL expose: to_if_valid output 1, PC handed to IF this cycle.
REQ-012 SHALL expose: to_if_bus output 33, {pc[31:0], adef}.

Function
REQ-013 SHALL hold pc_reg, the last PC handed to IF; seq_pc = pc_reg + 4, with 32-bit wrap (0xfffffffc + 4 = 0x00000000).
REQ-014 SHALL select pre_pc by priority: flush -> excep_entry; else redir_valid -> redir_pc; else br_taken -> br_target; else seq_pc.
REQ-015 SHALL drive inst_sram_req = ~reset & if_allowin & ~br_stall & ~pre_adef; flush overrides br_stall.
REQ-016 SHALL define handshake hs = inst_sram_req & inst_sram_addr_ok, or, for adef PCs, if_allowin & (~br_stall | flush); no memory request is issued for adef PCs.
REQ-017 SHALL assert to_if_valid = hs combinationally; to_if_bus = {pre_pc, pre_adef}; zero added latency.
REQ-018 SHALL load pc_reg <= pre_pc on hs only; pc_reg, inst_sram_addr and inst_sram_req SHALL hold stable while req=1 and addr_ok=0, unless a new flush or branch arrives.
REQ-019 SHALL capture redirects without loss: flush or br_taken in a cycle without hs -> redir_valid <= 1, redir_pc <= (flush ? excep_entry : br_target).
REQ-020 SHALL let a later flush overwrite a pending branch redirect; a later br_taken SHALL NOT overwrite a pending flush redirect; flush-origin is tracked by redir_is_flush.
REQ-021 SHALL clear redir_valid on hs; a redirect arriving in the same cycle as hs is consumed by that hs (pre_pc already selects it) and SHALL NOT be latched.
REQ-022 SHALL, with br_stall=1 and no flush, issue no request and no hs, and hold all state.
REQ-023 SHALL ignore inst_sram_addr_ok when inst_sram_req=0.

Reset
REQ-024 SHALL on reset set pc_reg = 0x1bfffffc, redir_valid = 0, redir_is_flush = 0, redir_pc = 0; outputs during reset: inst_sram_req = 0, to_if_valid = 0.
REQ-025 SHALL make the first request after reset deassertion use address 0x1c000000.
REQ-026 SHALL treat reset asserted mid-handshake as dominant: the pending redirect is discarded and pc_reg is not updated that cycle.

Configuration
REQ-027 SHALL support macro PRE_IF_ADEF_EN.
REQ-028 SHALL, when PRE_IF_ADEF_EN is defined, set pre_adef = |pre_pc[1:0] and apply REQ-015/016.
REQ-029 SHALL, when PRE_IF_ADEF_EN is undefined, tie pre_adef = 0, and misaligned pre_pc is requested as-is.

Verification
REQ-030 SHALL cover reset release, if_allowin=1, addr_ok=1 -> addresses 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles, adef=0.
REQ-031 SHALL cover addr_ok=0 for 3 cycles at 0x1c000004 -> req and addr held stable; single hs on the 4th cycle; pc_reg = 0x1c000004.
REQ-032 SHALL cover br_taken to 0x1c000100 for 1 cycle while addr_ok=0, then flush to 0x1c008000 while addr_ok=0; addr_ok=1 later -> one hs at 0x1c008000, then 0x1c008004.
REQ-033 SHALL cover br_stall=1 for 2 cycles -> req=0, to_if_valid=0; then br_taken to 0x1c000200 with br_stall=0 -> same-cycle hs at 0x1c000200, redir_valid stays 0.
REQ-034 SHALL cover, with PRE_IF_ADEF_EN, br_target 0x1c000102 -> req=0, to_if_valid=1, to_if_bus = {0x1c000102, 1}; without the macro -> req=1, addr 0x1c000102, adef=0.
